// File: rtl/spectrum_readout.sv
`default_nettype none
// ============================================================================
// Module   : spectrum_readout
// Brief    : Streams the histogram RAM out as a byte frame to the UART TX:
//            two header bytes, every channel count as 4 bytes MSB first,
//            then a modulo-256 checksum of the count bytes.
// Revision : 1.0  initial release
// ============================================================================
module spectrum_readout #(
  parameter int         N_CHANNELS   = 1024,
  parameter int         ADDR_W       = 10,
  parameter int         READ_LATENCY = 1,
  parameter logic [7:0] HDR0         = 8'hA5,
  parameter logic [7:0] HDR1         = 8'h5A
) (
  input  logic              CLOCK_65,
  input  logic              rst_n,
  input  logic              cmd_dump,
  input  logic              cmd_abort,
  output logic [ADDR_W-1:0] channel_address_read,
  input  logic [31:0]       channel_count_read,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_hdr   = 3'd1;
  localparam logic [2:0] c_st_fetch = 3'd2;
  localparam logic [2:0] c_st_send  = 3'd3;
  localparam logic [2:0] c_st_csum  = 3'd4;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(N_CHANNELS - 1);
  // FETCH spends READ_LATENCY wait cycles, then latches on the next one
  localparam logic [1:0]        c_wait_last = 2'(READ_LATENCY);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_csum;
  logic              r_dump_q;
  logic [23:0]       r_shift;   // remaining three bytes of the current count
  logic [1:0]        r_bcnt;    // bytes of the current count already sent
  logic [1:0]        r_wait;
  logic              r_hdr_sel; // 0: HDR0 on the bus, 1: HDR1 on the bus

  logic              w_xfer;
  logic              w_dump_rise;
  logic [7:0]        w_csum_next;

  assign w_xfer      = r_tx_valid & tx_ready;
  assign w_dump_rise = cmd_dump & ~r_dump_q;
  assign w_csum_next = r_csum + r_tx_data;

  assign channel_address_read = r_addr;
  assign tx_data              = r_tx_data;
  assign tx_valid             = r_tx_valid;
  assign busy                 = r_busy;
  assign done                 = r_done;

  // Frame sequencer: header, per-channel fetch/send, checksum; abort wins
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_addr     <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_csum     <= 8'h00;
      r_dump_q   <= 1'b0;
      r_shift    <= 24'h0;
      r_bcnt     <= 2'd0;
      r_wait     <= 2'd0;
      r_hdr_sel  <= 1'b0;
    end else begin
      r_dump_q <= cmd_dump;
      r_done   <= 1'b0;
      if (cmd_abort && (r_state != c_st_idle)) begin
        r_state    <= c_st_idle;
        r_tx_valid <= 1'b0;
        r_busy     <= 1'b0;
        r_addr     <= '0;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (w_dump_rise) begin
              r_csum     <= 8'h00;
              r_addr     <= '0;
              r_busy     <= 1'b1;
              r_tx_valid <= 1'b1;
              r_tx_data  <= HDR0;
              r_hdr_sel  <= 1'b0;
              r_state    <= c_st_hdr;
            end
          end
          c_st_hdr: begin
            if (w_xfer) begin
              if (!r_hdr_sel) begin
                r_tx_data <= HDR1;
                r_hdr_sel <= 1'b1;
              end else begin
                r_tx_valid <= 1'b0;
                r_wait     <= 2'd0;
                r_state    <= c_st_fetch;
              end
            end
          end
          c_st_fetch: begin
            if (r_wait == c_wait_last) begin
              r_tx_data  <= channel_count_read[31:24];
              r_shift    <= channel_count_read[23:0];
              r_tx_valid <= 1'b1;
              r_bcnt     <= 2'd0;
              r_state    <= c_st_send;
            end else begin
              r_wait <= r_wait + 2'd1;
            end
          end
          c_st_send: begin
            if (w_xfer) begin
              r_csum    <= w_csum_next;
              r_tx_data <= r_shift[23:16];
              r_shift   <= {r_shift[15:0], 8'h00};
              r_bcnt    <= r_bcnt + 2'd1;
              if (r_bcnt == 2'd3) begin
                if (r_addr == c_last_addr) begin
                  // checksum byte goes out directly, including the byte just sent
                  r_tx_data <= w_csum_next;
                  r_state   <= c_st_csum;
                end else begin
                  r_tx_valid <= 1'b0;
                  r_addr     <= r_addr + 1'b1;
                  r_wait     <= 2'd0;
                  r_state    <= c_st_fetch;
                end
              end
            end
          end
          c_st_csum: begin
            if (w_xfer) begin
              r_tx_valid <= 1'b0;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= c_st_idle;
            end
          end
          default: begin
            r_state    <= c_st_idle;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spectrum_readout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spectrum_readout
// Brief    : Bench for spectrum_readout; two instances (read latency 1 and 3)
//            share the command and handshake inputs and each has its own RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_spectrum_readout;

  logic        CLOCK_65 = 1'b0;
  logic        rst_n, cmd_dump, cmd_abort, tx_ready;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  txd_a, txd_b;
  logic        txv_a, txv_b, busy_a, busy_b, done_a, done_b;

  int total = 0;
  int bad   = 0;

  // Clock generation
  always #5 CLOCK_65 = ~CLOCK_65;

  spectrum_readout #(.N_CHANNELS(1024), .ADDR_W(10), .READ_LATENCY(1)) dut_a (
    .CLOCK_65(CLOCK_65), .rst_n(rst_n), .cmd_dump(cmd_dump), .cmd_abort(cmd_abort),
    .channel_address_read(addr_a), .channel_count_read(rd_a),
    .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(tx_ready), .busy(busy_a), .done(done_a));

  spectrum_readout #(.N_CHANNELS(1024), .ADDR_W(10), .READ_LATENCY(3)) dut_b (
    .CLOCK_65(CLOCK_65), .rst_n(rst_n), .cmd_dump(cmd_dump), .cmd_abort(cmd_abort),
    .channel_address_read(addr_b), .channel_count_read(rd_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(tx_ready), .busy(busy_b), .done(done_b));

  // RAM models: latency 1 and latency 3 synchronous reads of the same contents
  logic [31:0] mem [0:1023];
  logic [31:0] pipe_b0, pipe_b1, pipe_b2;
  always @(posedge CLOCK_65) begin
    rd_a    <= mem[addr_a];
    pipe_b0 <= mem[addr_b];
    pipe_b1 <= pipe_b0;
    pipe_b2 <= pipe_b1;
  end
  assign rd_b = pipe_b2;

  // Byte collectors and handshake-rule watchers, sampled mid-cycle
  logic [7:0] q_a[$], q_b[$];
  int dones_a = 0, dones_b = 0, viol_a = 0, viol_b = 0;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] hold_a, hold_b;
  always @(negedge CLOCK_65) begin
    if (rst_n) begin
      if (stall_a && !(txv_a === 1'b1 && txd_a === hold_a)) viol_a++;
      if (stall_b && !(txv_b === 1'b1 && txd_b === hold_b)) viol_b++;
      if (done_a && busy_a !== 1'b0) viol_a++;
      if (done_b && busy_b !== 1'b0) viol_b++;
      if (done_a) dones_a++;
      if (done_b) dones_b++;
      if (txv_a && tx_ready && !cmd_abort) q_a.push_back(txd_a);
      if (txv_b && tx_ready && !cmd_abort) q_b.push_back(txd_b);
      stall_a = txv_a && !tx_ready && !cmd_abort;
      stall_b = txv_b && !tx_ready && !cmd_abort;
      hold_a  = txd_a;
      hold_b  = txd_b;
    end else begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end
  end

  // ---------------------------------------------------------------- helpers
  int rmode = 0;   // 0: tx_ready as set, 1: random, 2: high one cycle in three
  int phase = 0;
  int start_a, start_b, d0_a, d0_b, v0_a, v0_b;
  logic [7:0] exp_q[$], fr_a[$], fr_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_65);
    #1;
    if (rmode == 1) tx_ready = ($urandom_range(0, 1) == 0);
    else if (rmode == 2) begin
      tx_ready = (phase == 0);
      phase    = (phase + 1) % 3;
    end
  endtask

  // Expected frame computed straight from the frame definition
  task automatic build_exp();
    logic [7:0] sum;
    logic [31:0] w;
    exp_q.delete();
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 1024; i++) begin
      w = mem[i];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
    end
    exp_q.push_back(sum);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] s[$]);
    int n, idx;
    chk({tag, "_len"}, s.size(), exp_q.size());
    n   = (s.size() < exp_q.size()) ? s.size() : exp_q.size();
    idx = n - 1;
    for (int i = 0; i < n; i++)
      if (s[i] !== exp_q[i]) begin idx = i; break; end
    if (n > 0) chk({tag, "_byte"}, s[idx], exp_q[idx]);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_txv_a"}, txv_a, 1'b0);   chk({tag, "_txv_b"}, txv_b, 1'b0);
    chk({tag, "_busy_a"}, busy_a, 1'b0); chk({tag, "_busy_b"}, busy_b, 1'b0);
    chk({tag, "_done_a"}, done_a, 1'b0); chk({tag, "_done_b"}, done_b, 1'b0);
    chk({tag, "_addr_a"}, addr_a, 0);    chk({tag, "_addr_b"}, addr_b, 0);
    chk({tag, "_txd_a"}, txd_a, 8'h00);  chk({tag, "_txd_b"}, txd_b, 8'h00);
  endtask

  task automatic pulse_dump();
    cmd_dump = 1'b1;
    step();
    step();
    cmd_dump = 1'b0;
  endtask

  task automatic begin_frame(input int mode);
    start_a = q_a.size(); start_b = q_b.size();
    d0_a = dones_a; d0_b = dones_b; v0_a = viol_a; v0_b = viol_b;
    rmode = mode;
    phase = 0;
    if (mode == 0) tx_ready = 1'b1;
    pulse_dump();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy_a || busy_b) && n < budget) begin step(); n++; end
    chk({tag, "_timeout"}, (n >= budget), 1'b0);
  endtask

  task automatic wait_addr(input int target, input int budget);
    int n = 0;
    while (!(addr_a == 10'(target) && txv_a) && n < budget) begin step(); n++; end
    chk("wait_addr_timeout", (n >= budget), 1'b0);
  endtask

  task automatic end_frame(input string tag);
    wait_idle(tag, 60000);
    rmode = 0;
    tx_ready = 1'b1;
    repeat (2) step();
    fr_a = q_a[start_a:$];
    fr_b = q_b[start_b:$];
    build_exp();
    check_frame({tag, "_a"}, fr_a);
    check_frame({tag, "_b"}, fr_b);
    chk({tag, "_dones_a"}, dones_a - d0_a, 1);
    chk({tag, "_dones_b"}, dones_b - d0_b, 1);
    chk({tag, "_rules_a"}, viol_a - v0_a, 0);
    chk({tag, "_rules_b"}, viol_b - v0_b, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int act;
    rst_n = 1'b0; cmd_dump = 1'b0; cmd_abort = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = i;
    repeat (3) @(posedge CLOCK_65);
    #1 rst_n = 1'b1;
    @(negedge CLOCK_65);
    chk_idle("reset");

    // Ramp contents, ready held high
    begin_frame(0);
    end_frame("ramp");
    chk("ramp_b4096", fr_a[4096], 8'h03);
    chk("ramp_b4097", fr_a[4097], 8'hFF);
    chk("ramp_csum", fr_a[4098], 8'h00);

    // Single marked channel, ready high one cycle in three
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;
    begin_frame(2);
    end_frame("mark");
    chk("mark_b22", fr_a[22], 8'hDE);
    chk("mark_b25", fr_a[25], 8'hEF);
    chk("mark_csum", fr_a[4098], 8'h38);

    // Constant contents with a dump re-pulse mid-frame (must be ignored)
    for (int i = 0; i < 1024; i++) mem[i] = 32'h01020304;
    begin_frame(0);
    wait_addr(100, 2000);
    cmd_dump = 1'b1;
    step(); step();
    cmd_dump = 1'b0;
    end_frame("repulse");
    chk("repulse_csum_b", fr_b[4098], 8'h00);

    // Random contents with random ready
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    begin_frame(1);
    end_frame("rand");

    // Abort while stalled in the middle of a channel
    begin_frame(0);
    wait_addr(300, 4000);
    tx_ready = 1'b0;
    act = 0;
    while (!txv_a && act < 20) begin step(); act++; end
    d0_a = dones_a; d0_b = dones_b;
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("abort_txv_a", txv_a, 1'b0);   chk("abort_txv_b", txv_b, 1'b0);
    chk("abort_busy_a", busy_a, 1'b0); chk("abort_busy_b", busy_b, 1'b0);
    chk("abort_addr_a", addr_a, 0);
    step();
    chk("abort_nodone_a", dones_a - d0_a, 0);
    chk("abort_nodone_b", dones_b - d0_b, 0);
    begin_frame(0);
    end_frame("restart");
    chk("restart_first", fr_a[0], 8'hA5);

    // Asynchronous reset while sending
    begin_frame(0);
    wait_addr(50, 2000);
    rst_n = 1'b0;
    #2;
    chk_idle("midrst");
    @(posedge CLOCK_65);
    #1 rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy_a || busy_b || txv_a || txv_b) act++;
    end
    chk("midrst_stays_idle", act, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
